discrete_mac_sequencer: RTL and testbench
=========================================

Name: discrete_mac_sequencer

Overview:
Time-multiplexed controller for one state-update equation of a discrete-circuit model, of the form x[n+1] = sat((c0*x[n] + sum ci*u_i[n]) >>> FRAC). It replaces a bank of parallel constant multipliers with one shared signed MAC, which it sequences one term per clock.
The block generates the solver sample tick internally, holds the runtime-writable coefficient table, and owns the state register.
It sits between the normalized audio/control inputs and the downstream output scaler.

Parameters:
- N_IN, 3, number of input terms u_i (coefficient table holds N_IN+1 entries).
- DATA_W, 16, width of inputs, state and output (signed two's complement).
- COEF_W, 16, coefficient width (signed).
- FRAC, 12, fractional bits of the coefficients; applied as the final right shift.
- TICK_DIV, 1024, clk cycles per solver step (>= 2).

Ports:
- clk, input, 1, solver clock.
- rst, input, 1, asynchronous active-high reset.
- run, input, 1, enables the tick divider; low holds the divider at 0.
- in_flat, input, N_IN*DATA_W, u_i at bits [i*DATA_W +: DATA_W], signed.
- cfg_we, input, 1, coefficient write strobe.
- cfg_addr, input, clog2(N_IN+1), 0 = c0 (state feedback), k = coefficient of u_(k-1).
- cfg_data, input, COEF_W, coefficient value.
- cfg_ready, output, 1, high when a write is accepted (FSM in IDLE).
- clr_flags, input, 1, synchronous clear of sticky flags.
- state_out, output, DATA_W, current x[n].
- out_valid, output, 1, one-cycle pulse when state_out updates.
- busy, output, 1, FSM not in IDLE.
- overrun, output, 1, sticky: a tick arrived while busy.
- sat_flag, output, 1, sticky: a saturation occurred.

Behaviour:
- Reset: all outputs 0, coefficient table 0, divider 0, FSM IDLE. The async assert takes effect immediately, including mid-MAC; there is no partial state write.
- Divider: counts 0..TICK_DIV-1 while run=1; tick is asserted for one cycle when the count wraps to 0.
- FSM states and transitions:
  - IDLE: on tick, snapshot in_flat and state into shadow regs, acc<=0, idx<=0, go to MAC.
  - MAC: one term per cycle, N_IN+1 cycles. idx=0 uses c0*x; idx=k uses ck*u_(k-1). acc += 32-bit signed product. After idx=N_IN, go to WB.
  - WB: r = acc >>> FRAC (arithmetic, floor). Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. state<=result, out_valid=1 for this one cycle, sat_flag set if clipped, then go to IDLE.
- Latency: tick high in cycle t → out_valid high in cycle t+N_IN+3, with state_out valid the same cycle.
- Widths: ACC_W = DATA_W+COEF_W+clog2(N_IN+1)+1; the accumulator never wraps.
- Tick while busy: the tick is dropped and overrun is set. The computation in progress is unaffected.
- cfg_we while cfg_ready=0: the write is ignored and the table is unchanged.
- cfg_we in the same cycle as the tick in IDLE: the write is accepted, and the step starting now uses the new value. The table write has priority and the MAC reads in the following cycles.
- clr_flags coinciding with a new flag event: the set wins.
- run deasserted mid-computation: the current step completes; no further ticks.
- Inputs are sampled only at the snapshot; changes during MAC have no effect.

Test Plan:
- Reset then idle: run=1, TICK_DIV=16, all coefs 0, inputs 1000 → out_valid every 16 cycles, state_out stays 0; no flags.
- Integrator: c0=4096, c1=2048, u0=1000, others 0 → state_out 500, 1000, 1500 on successive out_valid; out_valid exactly N_IN+3 cycles after each tick.
- Saturation plus floor:
  - c0=4096, c1=4096, u0=32767 → state_out 32767 on every step, sat_flag=1 from step 2.
  - Separately, c0=0, c1=2048, u0=-3 → state_out -2, no sat_flag.
- Overrun: N_IN=3, TICK_DIV=4 → each step needs 6 cycles, so ticks are dropped, overrun=1, and outputs stay consistent. clr_flags then clears overrun, and it is set again on the next collision.
- Config gating: cfg_we with c1=4096 during MAC → ignored and the step result is unchanged. The same write issued in IDLE is used by the next step.
- Reset mid-MAC: assert rst two cycles into MAC → state_out=0, busy=0, table zeroed, no out_valid pulse.

Source files
------------

// File: rtl/discrete_mac_sequencer.sv
// rtl/discrete_mac_sequencer.sv - time-multiplexed signed MAC solver for one discrete state-update equation
module discrete_mac_sequencer #(
    parameter int N_IN     = 3,
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int FRAC     = 12,
    parameter int TICK_DIV = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic [N_IN*DATA_W-1:0]       in_flat,
    input  logic                         cfg_we,
    input  logic [$clog2(N_IN+1)-1:0]    cfg_addr,
    input  logic [COEF_W-1:0]            cfg_data,
    output logic                         cfg_ready,
    input  logic                         clr_flags,
    output logic [DATA_W-1:0]            state_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         sat_flag
);

    localparam int AW    = $clog2(N_IN+1);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = DATA_W + COEF_W + $clog2(N_IN+1) + 1;
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB} fsm_t;

    fsm_t                      fsm;
    logic [CNT_W-1:0]          div_cnt;
    logic                      tick;
    logic signed [COEF_W-1:0]  coef [0:N_IN];
    logic [AW-1:0]             idx;
    logic signed [ACC_W-1:0]   acc;
    logic [DATA_W-1:0]         x_sh;
    logic [N_IN*DATA_W-1:0]    u_sh;

    logic signed [COEF_W-1:0]  coef_sel;
    logic signed [DATA_W-1:0]  data_sel;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   res;
    logic [DATA_W-1:0]         res_sat;
    logic                      res_clip;

    // Tick is registered so it is high for exactly one cycle per wrap of the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == CNT_W'(TICK_DIV-1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    // Writes land only while idle; a write coinciding with the tick is seen by the MAC next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= N_IN; k++) coef[k] <= '0;
        end else if (cfg_we && cfg_ready) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        coef_sel = coef[idx];
        data_sel = x_sh;
        for (int k = 1; k <= N_IN; k++) begin
            if (idx == AW'(k)) data_sel = u_sh[(k-1)*DATA_W +: DATA_W];
        end
        prod     = coef_sel * data_sel;
        prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
        res      = acc >>> FRAC;
        res_clip = 1'b0;
        res_sat  = res[DATA_W-1:0];
        if (res > MAX_V) begin
            res_sat  = MAX_V[DATA_W-1:0];
            res_clip = 1'b1;
        end else if (res < MIN_V) begin
            res_sat  = MIN_V[DATA_W-1:0];
            res_clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm       <= S_IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b0;
            out_valid <= 1'b0;
            state_out <= '0;
            overrun   <= 1'b0;
            sat_flag  <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            x_sh      <= '0;
            u_sh      <= '0;
        end else begin
            out_valid <= 1'b0;
            // Clear first so a same-cycle flag event below overrides it.
            if (clr_flags) begin
                overrun  <= 1'b0;
                sat_flag <= 1'b0;
            end
            if (tick && fsm != S_IDLE) overrun <= 1'b1;
            case (fsm)
                S_IDLE: begin
                    cfg_ready <= 1'b1;
                    if (tick) begin
                        x_sh      <= state_out;
                        u_sh      <= in_flat;
                        acc       <= '0;
                        idx       <= '0;
                        fsm       <= S_MAC;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc <= acc + prod_ext;
                    if (idx == AW'(N_IN)) fsm <= S_WB;
                    else                  idx <= idx + 1'b1;
                end
                S_WB: begin
                    state_out <= res_sat;
                    out_valid <= 1'b1;
                    if (res_clip) sat_flag <= 1'b1;
                    fsm       <= S_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    fsm       <= S_IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_discrete_mac_sequencer.sv
// tb/tb_discrete_mac_sequencer.sv - scoreboard bench for discrete_mac_sequencer
module tb_discrete_mac_sequencer;

    localparam int N_IN = 3;
    localparam int DW   = 16;
    localparam int CW   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1, run = 1'b0, cfg_we = 1'b0, clr_flags = 1'b0;
    logic [N_IN*DW-1:0]   in_flat = '0;
    logic [1:0]           cfg_addr = '0;
    logic [CW-1:0]        cfg_data = '0;
    logic                 cfg_ready, out_valid, busy, overrun, sat_flag;
    logic [DW-1:0]        state_out;

    logic                 rst4 = 1'b1, run4 = 1'b0, clr4 = 1'b0;
    logic                 cfg_ready4, out_valid4, busy4, overrun4, sat_flag4;
    logic [DW-1:0]        state_out4;

    discrete_mac_sequencer #(.N_IN(N_IN), .DATA_W(DW), .COEF_W(CW), .FRAC(12), .TICK_DIV(16)) dut (
        .clk(clk), .rst(rst), .run(run), .in_flat(in_flat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .clr_flags(clr_flags), .state_out(state_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun), .sat_flag(sat_flag));

    discrete_mac_sequencer #(.N_IN(N_IN), .DATA_W(DW), .COEF_W(CW), .FRAC(12), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst4), .run(run4), .in_flat('0),
        .cfg_we(1'b0), .cfg_addr(2'd0), .cfg_data(16'd0), .cfg_ready(cfg_ready4),
        .clr_flags(clr4), .state_out(state_out4), .out_valid(out_valid4),
        .busy(busy4), .overrun(overrun4), .sat_flag(sat_flag4));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_tick = -1000;
    int exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every out_valid pulse of the main DUT.
    always @(negedge clk) begin
        if (rst) begin
            last_tick = -1000;
        end else begin
            if (dut.tick) last_tick = cyc;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("state_out", int'($signed(state_out)), exp_q.pop_front());
                    chk("latency", cyc - last_tick, N_IN + 3);
                end
            end
        end
    end

    task automatic step_clk();
        @(posedge clk); #1;
    endtask

    task automatic wr(input int addr, input int data);
        cfg_addr = 2'(addr);
        cfg_data = 16'(data);
        cfg_we   = 1'b1;
        step_clk();
        cfg_we   = 1'b0;
    endtask

    task automatic set_in(input int u0, input int u1, input int u2);
        in_flat = {16'(u2), 16'(u1), 16'(u0)};
    endtask

    task automatic wait_ov(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_busy(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        if (!ok) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic run_steps(input int n, input string name);
        step_clk();
        run = 1'b1;
        for (int i = 0; i < n; i++) wait_ov(name);
        step_clk();
        run = 1'b0;
        repeat (2) step_clk();
    endtask

    initial begin
        int nov;
        bit ok;
        repeat (3) step_clk();
        @(negedge clk);
        chk("rst_state_out", int'(state_out), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 0);
        chk("rst_flags", int'({overrun, sat_flag}), 0);
        step_clk();
        rst = 1'b0;
        rst4 = 1'b0;
        repeat (2) step_clk();

        // All coefficients zero: output stays 0.
        set_in(1000, 1000, 1000);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        run_steps(3, "idle");
        chk("idle_flags", int'({overrun, sat_flag}), 0);

        // Integrator.
        wr(0, 4096); wr(1, 2048);
        set_in(1000, 0, 0);
        exp_q.push_back(500); exp_q.push_back(1000); exp_q.push_back(1500);
        run_steps(3, "integ");

        // Flush state to 0, then saturating accumulation.
        wr(0, 0); wr(1, 0);
        exp_q.push_back(0);
        run_steps(1, "flush");
        wr(0, 4096); wr(1, 4096);
        set_in(32767, 0, 0);
        exp_q.push_back(32767);
        run_steps(1, "sat1");
        chk("sat_flag_step1", int'(sat_flag), 0);
        exp_q.push_back(32767);
        run_steps(1, "sat2");
        chk("sat_flag_step2", int'(sat_flag), 1);
        exp_q.push_back(32767);
        run_steps(1, "sat3");

        // Floor rounding of a negative result.
        clr_flags = 1'b1; step_clk(); clr_flags = 1'b0;
        @(negedge clk);
        chk("sat_flag_cleared", int'(sat_flag), 0);
        wr(0, 0); wr(1, 2048);
        set_in(-3, 0, 0);
        exp_q.push_back(-2);
        run_steps(1, "floor");
        chk("floor_sat_flag", int'(sat_flag), 0);

        // Write during MAC is ignored; the same write in IDLE takes effect.
        wr(1, 0);
        set_in(100, 0, 0);
        exp_q.push_back(0);
        step_clk();
        run = 1'b1;
        wait_busy("gate");
        chk("cfg_ready_busy", int'(cfg_ready), 0);
        step_clk();
        cfg_addr = 2'd1; cfg_data = 16'd4096; cfg_we = 1'b1;
        step_clk();
        cfg_we = 1'b0;
        wait_ov("gate");
        step_clk();
        run = 1'b0;
        repeat (2) step_clk();
        wr(1, 4096);
        exp_q.push_back(100);
        run_steps(1, "gate2");

        // Reset two cycles into MAC: abort with no write-back, table cleared.
        set_in(500, 0, 0);
        step_clk();
        run = 1'b1;
        wait_busy("mid_rst");
        step_clk();
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_state", int'(state_out), 0);
        step_clk();
        rst = 1'b0;
        repeat (2) step_clk();
        set_in(500, 500, 500);
        exp_q.push_back(0);
        run_steps(1, "post_rst");
        repeat (10) step_clk();
        chk("scoreboard_empty", exp_q.size(), 0);

        // Overrun on a divider shorter than the step length.
        run4 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (overrun4) ok = 1'b1;
        end
        chk("overrun_set", int'(ok), 1);
        nov = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (out_valid4) begin
                nov++;
                chk("ovr_state_out", int'(state_out4), 0);
            end
        end
        chk("ovr_out_valid_count", nov, 8);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid4) ok = 1'b1;
        end
        chk("ovr_sync_timeout", int'(ok), 1);
        clr4 = 1'b1;
        step_clk();
        clr4 = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", int'(overrun4), 0);
        repeat (8) @(negedge clk);
        chk("overrun_reset_again", int'(overrun4), 1);
        run4 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
